// File: rtl/result_streamer_if.sv
// Handshake bundle for result_streamer.
// Upstream snapshot port: in_valid/in_ready with in_acc plus the mode bits
// in_narrow, in_transpose and in_relu.
// Downstream byte port: out_valid/out_ready with out_data, out_last, out_sat.
// busy reports an active snapshot.
// slave = streamer view, master = producer/sink view.
interface result_streamer_if #(
    parameter int unsigned N     = 2,
    parameter int unsigned ACC_W = 16
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [N*N*ACC_W-1:0]   in_acc;
    logic                   in_narrow;
    logic                   in_transpose;
    logic                   in_relu;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_data;
    logic                   out_last;
    logic                   out_sat;
    logic                   busy;

    modport slave (
        input  in_valid, in_acc, in_narrow, in_transpose, in_relu, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sat, busy
    );

    modport master (
        output in_valid, in_acc, in_narrow, in_transpose, in_relu, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sat, busy
    );
endinterface

// File: rtl/result_streamer.sv
// Serialises an N x N accumulator snapshot into a byte stream.
// Ports: clk, rst_n (async active-low), bus (result_streamer_if.slave).
// A snapshot is captured on in_valid && in_ready. Its elements are emitted
// row-major, or column-major when transposed. In wide mode each element is
// emitted as ACC_W/8 bytes, MSB first. In narrow mode each element is
// emitted as one byte, saturated to a signed 8-bit value. ReLU is applied
// before either mode.
module result_streamer #(
    parameter int unsigned N     = 2,
    parameter int unsigned ACC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    result_streamer_if.slave  bus
);

    localparam int unsigned BPE        = ACC_W / 8;
    localparam int unsigned ELEMS      = N * N;
    localparam int unsigned WIDE_BYTES = ELEMS * BPE;
    localparam int unsigned ACC_TOTAL  = ELEMS * ACC_W;
    localparam int unsigned IDX_W      = $clog2(WIDE_BYTES);

    typedef enum logic {IDLE, STREAM} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       sat;
    } byte_t;

    // Byte at stream position idx for a given snapshot and mode.
    function automatic byte_t byte_at(
        input logic [ACC_TOTAL-1:0] acc,
        input logic                 narrow,
        input logic                 transpose,
        input logic                 relu,
        input logic [IDX_W-1:0]     idx
    );
        int unsigned              i, e, b, r, c, pos;
        int                       sv;
        logic signed [ACC_W-1:0]  v;
        logic [ACC_W-1:0]         sh;
        byte_t                    o;
        i = 32'(idx);
        if (narrow) begin
            e = i;
            b = 0;
        end else begin
            e = i / BPE;
            b = i % BPE;
        end
        if (transpose) begin
            c = e / N;
            r = e % N;
        end else begin
            r = e / N;
            c = e % N;
        end
        pos = r * N + c;
        v   = acc[pos*ACC_W +: ACC_W];
        if (relu && v[ACC_W-1]) begin
            v = '0;
        end
        o = '0;
        if (narrow) begin
            sv = int'(v);
            if (sv > 127) begin
                o.data = 8'h7F;
                o.sat  = 1'b1;
            end else if (sv < -128) begin
                o.data = 8'h80;
                o.sat  = 1'b1;
            end else begin
                o.data = v[7:0];
            end
            o.last = (i == ELEMS - 1);
        end else begin
            sh     = v >> ((BPE - 1 - b) * 8);
            o.data = sh[7:0];
            o.last = (i == WIDE_BYTES - 1);
        end
        return o;
    endfunction

    state_t                 state_q;
    logic [ACC_TOTAL-1:0]   acc_q;
    logic                   narrow_q;
    logic                   transpose_q;
    logic                   relu_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   out_valid_q;
    logic [7:0]             out_data_q;
    logic                   out_last_q;
    logic                   out_sat_q;
    logic                   busy_q;

    logic                   fire;
    logic                   in_ready_c;
    logic                   accept;
    logic [IDX_W-1:0]       idx_nxt;
    byte_t                  first_byte;
    byte_t                  next_byte;

    assign fire       = out_valid_q && bus.out_ready;
    // Ready in IDLE, or on the edge the final byte leaves (back-to-back).
    assign in_ready_c = (state_q == IDLE) || ((state_q == STREAM) && fire && out_last_q);
    assign accept     = bus.in_valid && in_ready_c;
    assign idx_nxt    = idx_q + IDX_W'(1);

    // First byte comes straight from the inputs so it appears one cycle after acceptance.
    assign first_byte = byte_at(bus.in_acc, bus.in_narrow, bus.in_transpose, bus.in_relu, '0);
    assign next_byte  = byte_at(acc_q, narrow_q, transpose_q, relu_q, idx_nxt);

    // Control FSM, snapshot capture and registered byte output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            narrow_q    <= 1'b0;
            transpose_q <= 1'b0;
            relu_q      <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            state_q     <= STREAM;
            acc_q       <= bus.in_acc;
            narrow_q    <= bus.in_narrow;
            transpose_q <= bus.in_transpose;
            relu_q      <= bus.in_relu;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= first_byte.data;
            out_last_q  <= first_byte.last;
            out_sat_q   <= first_byte.sat;
            busy_q      <= 1'b1;
        end else if (fire) begin
            if (out_last_q) begin
                state_q     <= IDLE;
                idx_q       <= '0;
                out_valid_q <= 1'b0;
                out_data_q  <= 8'h00;
                out_last_q  <= 1'b0;
                out_sat_q   <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                idx_q       <= idx_nxt;
                out_data_q  <= next_byte.data;
                out_last_q  <= next_byte.last;
                out_sat_q   <= next_byte.sat;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer (N=2, ACC_W=16). Expected bytes are
// queued when a snapshot is offered and compared when the sink takes them.
module tb_result_streamer;

    localparam int unsigned N     = 2;
    localparam int unsigned ACC_W = 16;

    localparam logic [63:0] DATA_A = {16'h7FFF, 16'h0080, 16'hFFFE, 16'h1234};
    localparam logic [63:0] DATA_B = {16'h7FFF, 16'h0080, 16'hFFFE, 16'h0100};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    result_streamer_if #(.N(N), .ACC_W(ACC_W)) bus ();

    result_streamer #(.N(N), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    int          popped   = 0;
    logic [9:0]  sb[$];
    bit          rand_rdy = 1'b0;
    bit          stalled  = 1'b0;
    logic [9:0]  held;
    logic [9:0]  expv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l, input logic s);
        sb.push_back({d, l, s});
    endtask

    task automatic push_bytes(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, input int cnt,
                              input logic [7:0] satmask);
        logic [7:0] a [8];
        a = '{b0, b1, b2, b3, b4, b5, b6, b7};
        for (int i = 0; i < cnt; i++) begin
            push(a[i], 1'(i == cnt - 1), satmask[i]);
        end
    endtask

    // Offer a snapshot from IDLE and check the one-cycle latency to the first byte.
    task automatic send(input logic [63:0] acc, input logic nar, input logic tr, input logic relu);
        int n;
        n = 0;
        bus.in_acc       = acc;
        bus.in_narrow    = nar;
        bus.in_transpose = tr;
        bus.in_relu      = relu;
        bus.in_valid     = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("first_byte_latency", 32'(bus.out_valid), 32'd1);
        check("busy_streaming", 32'(bus.busy), 32'd1);
        // Scramble inputs; only the captured copy may be used from here on.
        bus.in_acc       = {$urandom, $urandom};
        bus.in_narrow    = ~nar;
        bus.in_transpose = ~tr;
        bus.in_relu      = ~relu;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_in_time", 32'(n < max_cycles), 32'd1);
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    // Random sink back-pressure when enabled.
    always begin
        @(posedge clk); #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Sink monitor: values seen here are the ones taken at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", 32'(bus.out_data), 32'(held[9:2]));
                check("stall_last", 32'(bus.out_last), 32'(held[1]));
                check("stall_sat", 32'(bus.out_sat), 32'(held[0]));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_byte", 32'(bus.out_valid), 32'd0);
                end else begin
                    expv = sb.pop_front();
                    check("byte_data", 32'(bus.out_data), 32'(expv[9:2]));
                    check("byte_last", 32'(bus.out_last), 32'(expv[1]));
                    check("byte_sat", 32'(bus.out_sat), 32'(expv[0]));
                    popped++;
                end
                stalled = 1'b0;
            end else if (bus.out_valid) begin
                stalled = 1'b1;
                held    = {bus.out_data, bus.out_last, bus.out_sat};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base;
        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_acc       = '0;
        bus.in_narrow    = 1'b0;
        bus.in_transpose = 1'b0;
        bus.in_relu      = 1'b0;
        bus.out_ready    = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_sat", 32'(bus.out_sat), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        check("rst_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Wide, row-major
        push_bytes(8'h12, 8'h34, 8'hFF, 8'hFE, 8'h00, 8'h80, 8'h7F, 8'hFF, 8, 8'h00);
        send(DATA_A, 1'b0, 1'b0, 1'b0);
        drain(100);

        // Narrow with ReLU, then without
        push_bytes(8'h7F, 8'h00, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 4, 8'b0000_1101);
        send(DATA_B, 1'b1, 1'b0, 1'b1);
        drain(100);
        push_bytes(8'h7F, 8'hFE, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 4, 8'b0000_1101);
        send(DATA_B, 1'b1, 1'b0, 1'b0);
        drain(100);

        // Wide, column-major
        push_bytes(8'h12, 8'h34, 8'h00, 8'h80, 8'hFF, 8'hFE, 8'h7F, 8'hFF, 8, 8'h00);
        send(DATA_A, 1'b0, 1'b1, 1'b0);
        drain(100);

        // Random back-pressure; monitor also checks stability during stalls
        rand_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_bytes(8'h12, 8'h34, 8'hFF, 8'hFE, 8'h00, 8'h80, 8'h7F, 8'hFF, 8, 8'h00);
            send(DATA_A, 1'b0, 1'b0, 1'b0);
            drain(1000);
        end
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back snapshots with in_valid held high
        push_bytes(8'h12, 8'h34, 8'hFF, 8'hFE, 8'h00, 8'h80, 8'h7F, 8'hFF, 8, 8'h00);
        push_bytes(8'h7F, 8'hFE, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 4, 8'b0000_1101);
        bus.in_acc       = DATA_A;
        bus.in_narrow    = 1'b0;
        bus.in_transpose = 1'b0;
        bus.in_relu      = 1'b0;
        bus.in_valid     = 1'b1;
        @(posedge clk); #1;
        check("b2b_first_valid", 32'(bus.out_valid), 32'd1);
        bus.in_acc    = DATA_B;
        bus.in_narrow = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("b2b_no_bubble", 32'(bus.out_valid), 32'd1);
        check("b2b_second_first", 32'(bus.out_data), 32'h7F);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        drain(100);

        // Reset mid-stream after three bytes
        push_bytes(8'h12, 8'h34, 8'hFF, 8'hFE, 8'h00, 8'h80, 8'h7F, 8'hFF, 8, 8'h00);
        base = popped;
        send(DATA_A, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (popped < base + 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("pre_reset_bytes", 32'(popped - base), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_out_data", 32'(bus.out_data), 32'd0);
        check("midrst_out_last", 32'(bus.out_last), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_release_ready", 32'(bus.in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_resume", 32'(bus.out_valid), 32'd0);

        // Recovery with a fresh snapshot
        push_bytes(8'h12, 8'h34, 8'h00, 8'h80, 8'hFF, 8'hFE, 8'h7F, 8'hFF, 8, 8'h00);
        send(DATA_A, 1'b0, 1'b1, 1'b0);
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
